// File: rtl/reg_mask_encoder.sv
// ============================================================================
// reg_mask_encoder
// ----------------------------------------------------------------------------
// Sequential register-mask encoder. This block is the inverse of the 3-to-8
// register-select decoder. It takes an N-bit register mask with one bit per
// register. It then hands out the index of every set bit, one per handshake,
// in priority order. The multicycle control uses it to drive the decoder's W
// input during save/restore and register-dump sequences.
//
// Parameters
//    N          mask width, which is the number of registers
//    W          index width; must equal $clog2(N)
//    LSB_FIRST  1: lowest set bit is emitted first, 0: highest set bit first
//
// Ports
//    clock   in   1     rising-edge clock
//    reset   in   1     asynchronous, active-high reset
//    start   in   1     begin an operation; only looked at while idle
//    mask    in   N     register mask, captured on the accepted start
//    ready   in   1     consumer takes idx this cycle when valid is high
//    idx     out  W     index of the highest-priority pending register
//    valid   out  1     idx is meaningful
//    busy    out  1     high while emitting and during the done cycle
//    done    out  1     one-cycle pulse at the end of an operation
//    count   out  W+1   indices accepted in the current/last operation
//
// Every output comes straight from a flop. The next values of the outputs
// are computed from the next state. As a result, start/mask/ready never
// reach an output in the same cycle.
// ============================================================================
module reg_mask_encoder #(
   parameter int N         = 8,
   parameter int W         = 3,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] mask,
   input  logic         ready,
   output logic [W-1:0] idx,
   output logic         valid,
   output logic         busy,
   output logic         done,
   output logic [W:0]   count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } EncoderState;

   localparam logic [W:0] CountOne = {{W{1'b0}}, 1'b1};

   EncoderState  state;
   EncoderState  stateNext;
   logic [N-1:0] pending;
   logic [N-1:0] pendingNext;
   logic [N-1:0] headBit;
   logic [W-1:0] headIdx;
   logic [W:0]   countNext;
   logic [W-1:0] idxNext;
   logic         validNext;
   logic         busyNext;
   logic         doneNext;

   // Priority encoder over the pending set. The loop runs away from the
   // winning end, so the last assignment is always the highest-priority
   // set bit. An empty set encodes to zero, and callers only use the result
   // when the set is non-empty.
   function automatic logic [W-1:0] encodeIndex(input logic [N-1:0] bits);
      logic [W-1:0] result;
      result = '0;
      if (LSB_FIRST) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (bits[i]) begin
               result = W'(i);
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (bits[i]) begin
               result = W'(i);
            end
         end
      end
      return result;
   endfunction

   // Identify the register currently at the head of the queue, and build a
   // one-hot mask that retires it once the consumer accepts it.
   always_comb begin
      headIdx          = encodeIndex(pending);
      headBit          = '0;
      headBit[headIdx] = 1'b1;
   end

   // Next-state logic for the controller.
   // A start is honoured only from IDLE, so a start held high just retriggers
   // after the done cycle. While emitting, a transfer (pending non-empty and
   // ready high) retires the head bit and bumps the count. The controller
   // leaves for DONE on the same edge that clears the last bit. This keeps
   // back-to-back indices bubble-free and also makes an empty mask spend
   // exactly one cycle in EMIT.
   always_comb begin
      stateNext   = state;
      pendingNext = pending;
      countNext   = count;
      unique case (state)
         IDLE: begin
            if (start) begin
               pendingNext = mask;
               countNext   = '0;
               stateNext   = EMIT;
            end
         end
         EMIT: begin
            if (pending == '0) begin
               stateNext = DONE;
            end else if (ready) begin
               pendingNext = pending & ~headBit;
               countNext   = count + CountOne;
               if ((pending & ~headBit) == '0) begin
                  stateNext = DONE;
               end
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext   = IDLE;
            pendingNext = '0;
         end
      endcase
   end

   // Output values for the coming cycle are derived from the coming state.
   // This lets the registered outputs line up with the state they describe.
   // idx is driven to zero whenever it is not valid, so a consumer never sees
   // a stale index.
   always_comb begin
      validNext = (stateNext == EMIT) && (pendingNext != '0);
      idxNext   = validNext ? encodeIndex(pendingNext) : '0;
      busyNext  = (stateNext != IDLE);
      doneNext  = (stateNext == DONE);
   end

   // The single state register for the controller and all of its outputs.
   // Reset clears everything at once. An operation cut off by reset simply
   // disappears and never produces a done pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         pending <= '0;
         count   <= '0;
         idx     <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= stateNext;
         pending <= pendingNext;
         count   <= countNext;
         idx     <= idxNext;
         valid   <= validNext;
         busy    <= busyNext;
         done    <= doneNext;
      end
   end

endmodule

// File: tb/tb_reg_mask_encoder.sv
// ============================================================================
// tb_reg_mask_encoder
// ----------------------------------------------------------------------------
// Bench for reg_mask_encoder. It runs one LSB-first and one MSB-first
// instance side by side on shared inputs. The reference model keeps the
// captured mask as an ascending list of register numbers plus an accepted
// count:
//    - the LSB-first head is list[accepted]
//    - the MSB-first head is list[size-1-accepted]
// ============================================================================
module tb_reg_mask_encoder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       ready = 1'b0;
   logic [7:0] mask  = 8'h00;

   logic [2:0] idxL;
   logic       validL;
   logic       busyL;
   logic       doneL;
   logic [3:0] countL;
   logic [2:0] idxM;
   logic       validM;
   logic       busyM;
   logic       doneM;
   logic [3:0] countM;

   int checks      = 0;
   int failures    = 0;
   bit checkEnable = 1'b0;

   int mPhase    = 0;
   int mList[$];
   int mAccepted = 0;

   int seenL[$];
   int seenM[$];

   int expValid;
   int expIdxL;
   int expIdxM;

   reg_mask_encoder #(.N(8), .W(3), .LSB_FIRST(1'b1)) dutLsb (
      .clock(clock), .reset(reset), .start(start), .mask(mask), .ready(ready),
      .idx(idxL), .valid(validL), .busy(busyL), .done(doneL), .count(countL)
   );

   reg_mask_encoder #(.N(8), .W(3), .LSB_FIRST(1'b0)) dutMsb (
      .clock(clock), .reset(reset), .start(start), .mask(mask), .ready(ready),
      .idx(idxM), .valid(validM), .busy(busyM), .done(doneM), .count(countM)
   );

   // 10 ns clock.
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural reference model. On an accepted start it turns the mask
   // into a list of set register numbers. It then counts acceptances until
   // the list is used up, spends one done cycle, and returns to idle.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mPhase    = 0;
         mAccepted = 0;
         mList.delete();
      end else begin
         case (mPhase)
            0: if (start) begin
               mList.delete();
               for (int i = 0; i < 8; i++) if (mask[i]) mList.push_back(i);
               mAccepted = 0;
               mPhase    = 1;
            end
            1: begin
               if (mAccepted < mList.size() && ready) mAccepted++;
               if (mAccepted == mList.size()) mPhase = 2;
            end
            default: mPhase = 0;
         endcase
      end
   end

   // Every-cycle comparison of both instances against the model. Transfers
   // are also logged, so the directed tests can pin the emitted order.
   always @(negedge clock) begin
      if (!reset && checkEnable) begin
         expValid = ((mPhase == 1) && (mAccepted < mList.size())) ? 1 : 0;
         checkOutput("valid_lsb", validL, expValid);
         checkOutput("valid_msb", validM, expValid);
         checkOutput("busy_lsb", busyL, (mPhase != 0) ? 1 : 0);
         checkOutput("busy_msb", busyM, (mPhase != 0) ? 1 : 0);
         checkOutput("done_lsb", doneL, (mPhase == 2) ? 1 : 0);
         checkOutput("done_msb", doneM, (mPhase == 2) ? 1 : 0);
         checkOutput("count_lsb", countL, mAccepted);
         checkOutput("count_msb", countM, mAccepted);
         if (expValid == 1) begin
            expIdxL = mList[mAccepted];
            expIdxM = mList[mList.size() - 1 - mAccepted];
            checkOutput("idx_lsb", idxL, expIdxL);
            checkOutput("idx_msb", idxM, expIdxM);
         end
         if (validL && ready) seenL.push_back(int'(idxL));
         if (validM && ready) seenM.push_back(int'(idxM));
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic applyStimulus(input bit s, input logic [7:0] m, input bit r);
      start = s;
      mask  = m;
      ready = r;
   endtask

   task automatic checkSeq(input string name, input int got[$], input int exp[$]);
      checkOutput({name, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checkOutput(name, got[i], exp[i]);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_idx_lsb"}, idxL, 0);
      checkOutput({tag, "_valid_lsb"}, validL, 0);
      checkOutput({tag, "_busy_lsb"}, busyL, 0);
      checkOutput({tag, "_done_lsb"}, doneL, 0);
      checkOutput({tag, "_count_lsb"}, countL, 0);
      checkOutput({tag, "_idx_msb"}, idxM, 0);
      checkOutput({tag, "_valid_msb"}, validM, 0);
      checkOutput({tag, "_busy_msb"}, busyM, 0);
      checkOutput({tag, "_done_msb"}, doneM, 0);
      checkOutput({tag, "_count_msb"}, countM, 0);
   endtask

   // Start one operation with ready held high. Returns the number of edges
   // after the start edge until done is seen, and then lets the block idle.
   task automatic runDirected(input logic [7:0] m, output int cycles);
      seenL.delete();
      seenM.delete();
      applyStimulus(1'b1, m, 1'b1);
      tick();
      applyStimulus(1'b0, m, 1'b1);
      cycles = 0;
      while (!doneL && cycles < 40) begin
         tick();
         cycles++;
      end
      if (!doneL) checkOutput("done_timeout", 0, 1);
   endtask

   // Random operation: random mask, bursty ready, and stray start pulses.
   // It is then drained with ready high until the model reports idle.
   task automatic runRandomOp();
      int n;
      logic [7:0] m;
      int pick;
      pick = $urandom_range(0, 9);
      m = (pick == 0) ? 8'h00 : (pick == 1) ? 8'hFF : 8'($urandom);
      applyStimulus(1'b1, m, 1'($urandom));
      tick();
      n = 0;
      while (mPhase != 0 && n < 100) begin
         applyStimulus(($urandom_range(0, 4) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
         tick();
         n++;
      end
      start = 1'b0;
      ready = 1'b1;
      while (mPhase != 0 && n < 200) begin
         tick();
         n++;
      end
      if (mPhase != 0) checkOutput("op_timeout", mPhase, 0);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
   endtask

   initial begin
      int cyc;
      int e[$];

      // Power-up reset, then outputs must be all zero.
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      tick();
      checkResetOutputs("por");
      reset = 1'b0;
      checkEnable = 1'b1;
      tick();

      // Asynchronous reset in the middle of a cycle clears outputs at once.
      applyStimulus(1'b1, 8'hA6, 1'b0);
      tick();
      start = 1'b0;
      tick();
      checkOutput("pre_reset_valid", validL, 1);
      reset = 1'b1;
      #1;
      checkResetOutputs("midrst");
      tick();
      reset = 1'b0;
      tick();

      // Mask 1010_0110 in both priority orders.
      runDirected(8'hA6, cyc);
      e = '{1, 2, 5, 7};
      checkSeq("seq_a6_lsb", seenL, e);
      e = '{7, 5, 2, 1};
      checkSeq("seq_a6_msb", seenM, e);
      checkOutput("a6_done_latency", cyc, 4);
      checkOutput("a6_count", countL, 4);
      tick();
      checkOutput("a6_count_hold", countL, 4);
      checkOutput("a6_idle", busyL, 0);

      // All registers selected.
      runDirected(8'hFF, cyc);
      e = '{0, 1, 2, 3, 4, 5, 6, 7};
      checkSeq("seq_ff_lsb", seenL, e);
      e = '{7, 6, 5, 4, 3, 2, 1, 0};
      checkSeq("seq_ff_msb", seenM, e);
      checkOutput("ff_done_latency", cyc, 8);
      checkOutput("ff_count", countL, 8);
      tick();

      // Empty mask: no valid, done one edge after the EMIT cycle.
      runDirected(8'h00, cyc);
      checkOutput("zero_done_latency", cyc, 1);
      checkOutput("zero_count", countL, 0);
      checkOutput("zero_seen", seenL.size(), 0);
      tick();

      // Backpressure on mask 1000_0001, with a stray start during EMIT.
      seenL.delete();
      seenM.delete();
      applyStimulus(1'b1, 8'h81, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus((i == 0), 8'hFF, 1'b0);
         tick();
         checkOutput("bp_valid", validL, 1);
         checkOutput("bp_idx_lsb", idxL, 0);
         checkOutput("bp_idx_msb", idxM, 7);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      cyc = 0;
      while (!doneL && cyc < 40) begin
         tick();
         cyc++;
      end
      e = '{0, 7};
      checkSeq("seq_bp_lsb", seenL, e);
      e = '{7, 0};
      checkSeq("seq_bp_msb", seenM, e);
      checkOutput("bp_count", countL, 2);
      tick();

      // Reset after two of four transfers; no done pulse may follow.
      applyStimulus(1'b1, 8'h3C, 1'b1);
      tick();
      start = 1'b0;
      tick();
      tick();
      checkOutput("abort_count_before", countL, 2);
      reset = 1'b1;
      #1;
      checkResetOutputs("abort");
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("abort_no_done", doneL, 0);
         checkOutput("abort_idle", busyL, 0);
      end
      runDirected(8'h10, cyc);
      e = '{4};
      checkSeq("seq_10_lsb", seenL, e);
      checkSeq("seq_10_msb", seenM, e);
      checkOutput("post_abort_count", countL, 1);
      tick();

      // Randomised operations against the model.
      for (int k = 0; k < 60; k++) runRandomOp();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
